// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed memory.
// Little-endian byte lanes; sub-word stores use a read-modify-write through
// a MERGE state, all other accesses complete with one cycle of latency.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W accesses are
// reported through misalign instead of being silently aligned).
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            misalign,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t          state, next_state;

  logic            accept;
  logic            is_half, is_word;
  logic            legal;
  logic            mis;
  logic [1:0]      eff_off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;

  logic [XLEN-1:0] lat_addr;
  logic [15:0]     lat_wdata;
  logic [2:0]      lat_funct3;
  logic [XLEN-1:0] lat_word;
  logic [XLEN-1:0] merged;

  logic            latch_en;
  logic            rsp_set;
  logic [XLEN-1:0] rsp_data_d;
  logic            mem_we_raw;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Access-type decode and legality check.
  always_comb begin
    is_half = (req_funct3[1:0] == 2'b01);
    is_word = (req_funct3 == 3'b010);
    if (req_we)
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned halfword/word accesses are trapped, offsets used as given.
  always_comb begin
    mis     = legal && ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
    eff_off = req_addr[1:0];
  end
`else
  // Offending low address bits are cleared so the access stays aligned.
  always_comb begin
    mis = 1'b0;
    if (is_word)
      eff_off = 2'b00;
    else if (is_half)
      eff_off = {req_addr[1], 1'b0};
    else
      eff_off = req_addr[1:0];
  end
`endif

  assign byte_sel = mem_rd[{eff_off, 3'b000} +: 8];
  assign half_sel = mem_rd[{eff_off[1], 4'b0000} +: 16];

  // Lane select and sign/zero extension of load data.
  always_comb begin
    case (req_funct3)
      3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val = mem_rd;
    endcase
  end

  // Replace only the targeted byte/half in the word captured at accept.
  always_comb begin
    merged = lat_word;
    if (lat_funct3 == 3'b001)
      merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata;
    else
      merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
  end

  // Next-state, memory-port and response decisions.
  always_comb begin
    next_state = state;
    mem_we_raw = 1'b0;
    mem_addr   = {2'b00, req_addr[XLEN-1:2]};
    mem_wd     = req_wdata;
    latch_en   = 1'b0;
    rsp_set    = 1'b0;
    rsp_data_d = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal || mis) begin
            rsp_set = 1'b1;
          end else if (!req_we) begin
            rsp_set    = 1'b1;
            rsp_data_d = load_val;
          end else if (is_word) begin
            mem_we_raw = 1'b1;
            rsp_set    = 1'b1;
          end else begin
            latch_en   = 1'b1;
            next_state = MERGE;
          end
        end
      end
      MERGE: begin
        mem_addr   = {2'b00, lat_addr[XLEN-1:2]};
        mem_wd     = merged;
        mem_we_raw = 1'b1;
        rsp_set    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write enable is killed combinationally by reset so an in-flight merge never lands.
  assign mem_we = mem_we_raw && rst;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_set;
      rsp_rdata <= rsp_data_d;
    end
  end

  // Sub-word store context captured in the accept cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_word   <= '0;
    end else if (latch_en) begin
      lat_addr   <= {req_addr[XLEN-1:2], eff_off};
      lat_wdata  <= req_wdata[15:0];
      lat_funct3 <= req_funct3;
      lat_word   <= mem_rd;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalign flag travels with the response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign <= 1'b0;
    else      misalign <= accept && mis;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  access request from the execute stage.
REQ-005 SHALL have port req_we  input  1  1 means store, 0 means load.
REQ-006 SHALL have port req_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port req_addr  input  XLEN  byte address.
REQ-008 SHALL have port req_wdata  input  XLEN  store data, right-aligned.
REQ-009 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  XLEN  extended load result; 0 for stores.
REQ-012 SHALL have port misalign  output  1  misaligned-access flag, valid with rsp_valid.
REQ-013 SHALL have port mem_we  output  1  word-memory write enable.
REQ-014 SHALL have port mem_addr  output  XLEN  word index, req_addr>>2 zero-extended.
REQ-015 SHALL have port mem_wd  output  XLEN  word-memory write data.
REQ-016 SHALL have port mem_rd  input  XLEN  word-memory combinational read data.

Function
REQ-017 SHALL be little-endian: byte k of the word is bits [8k+7:8k], with k = addr[1:0].
REQ-018 SHALL implement FSM states IDLE and MERGE, with req_ready = (state == IDLE).
REQ-019 Loads SHALL drive mem_addr combinationally, select the byte/half from mem_rd, and sign-extend for B/H or zero-extend for BU/HU into rsp_rdata.
REQ-020 Loads SHALL register rsp_rdata and pulse rsp_valid on the next edge (latency 1).
REQ-021 Store W SHALL assert mem_we with mem_wd = req_wdata in the accept cycle, then pulse rsp_valid on the next edge.
REQ-022 Store B/H SHALL latch addr, wdata, funct3 and mem_rd in the accept cycle and transition IDLE -> MERGE.
REQ-023 In MERGE the unit SHALL assert mem_we for exactly one cycle with mem_wd = latched word with only the targeted byte/half replaced, then return to IDLE.
REQ-024 Store B/H SHALL pulse rsp_valid on the edge that leaves MERGE (total latency 2).
REQ-025 mem_we SHALL be 0 in every other case.
REQ-026 Back-to-back loads and W stores SHALL be accepted every cycle; acceptance SHALL be allowed in the same cycle that rsp_valid of the prior access is high.
REQ-027 An illegal encoding (funct3 011/110/111, or store with 100/101) SHALL perform no memory access and pulse rsp_valid after 1 cycle with rsp_rdata = 0 and misalign = 0.
REQ-028 rsp_valid SHALL never assert without a prior accepted request.

Reset
REQ-029 rst low SHALL asynchronously force state = IDLE, rsp_valid = 0, rsp_rdata = 0, misalign = 0, and all latched registers to 0.
REQ-030 mem_we SHALL be gated to 0 combinationally while rst is low, including when reset is asserted mid-MERGE; the pending write is abandoned and produces no rsp_valid.
REQ-031 After rst rises, the first accept SHALL be possible in the first cycle.

Configuration
REQ-032 With macro MISALIGN_TRAP_EN defined, an H/HU access with addr[0] = 1, or a W access with addr[1:0] != 0, SHALL perform no memory access and pulse rsp_valid after 1 cycle with misalign = 1 and rsp_rdata = 0.
REQ-033 Without MISALIGN_TRAP_EN, misalign SHALL be tied to 0, and offending low address bits SHALL be cleared (H uses addr[1], W uses offset 0) before access.

Verification
REQ-034 Word 1 = 0x804020F0: LB at addr 0x7 -> one cycle later rsp_valid = 1, rsp_rdata = 0xFFFFFF80; LBU at 0x7 -> 0x00000080.
REQ-035 Word 1 = 0x804020F0: SH at 0x6 with wdata 0x1234ABCD -> req_ready = 0 for one cycle, one mem_we pulse with mem_addr = 1 and mem_wd = 0xABCD20F0, rsp_valid 2 cycles after accept.
REQ-036 Three back-to-back LW at 0x0, 0x4, 0x8 -> req_ready stays 1, three consecutive rsp_valid pulses with the three words in order.
REQ-037 With MISALIGN_TRAP_EN, LW at 0x5 -> mem_we = 0, rsp_valid + misalign = 1, rsp_rdata = 0; without it, rsp_rdata = word 1.
REQ-038 SB at 0x3, rst low during MERGE -> mem_we = 0 immediately, no rsp_valid, word unchanged, state IDLE after release.
